// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller poller.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } pad_state_t;

  // Bit positions of the buttons in the assembled byte (4021 shift order)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_COUNT  = BTN_RIGHT + 1;

  localparam int LATCH_TICKS = 2;
  localparam int FRAME_TICKS = 17;

endpackage

// File: rtl/nes_pad_tick.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk cycles.
module nes_pad_tick #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_tick_div: assert (TICK_DIV >= 2);
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls a 4021-based NES pad and presents an active-high button byte
// with a one-cycle update strobe, optionally debounced over two frames.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int TICK_DIV   = 300,
  parameter int POLL_TICKS = 2778,
  parameter int DEBOUNCE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] key,
  output logic       key_valid
);

  localparam int PW = $clog2(POLL_TICKS);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_TICKS - 1);
  localparam logic [2:0]    LATCH_LAST = 3'(LATCH_TICKS - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(BTN_RIGHT);

  logic                 tick;
  logic [1:0]           sync_reg;
  logic                 sample_bit;
  pad_state_t           state_reg, state_next;
  logic [PW-1:0]        poll_cnt_reg, poll_cnt_next;
  logic [2:0]           bit_cnt_reg, bit_cnt_next;
  logic [BTN_COUNT-1:0] shreg_reg, shreg_next;
  logic [BTN_COUNT-1:0] prev_reg;
  logic [BTN_COUNT-1:0] key_reg;
  logic                 key_valid_reg;
  logic                 pad_latch_reg;
  logic                 pad_clk_reg;

  nes_pad_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // pad_data is asynchronous to clk and active-low
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pad_data};
    end
  end

  assign sample_bit = ~sync_reg[1];

  // bit_cnt_reg doubles as the tick counter while LATCH is held
  always_comb begin
    state_next    = state_reg;
    poll_cnt_next = poll_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shreg_next    = shreg_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          if (poll_cnt_reg == POLL_LAST) begin
            poll_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = ST_LATCH;
          end else begin
            poll_cnt_next = poll_cnt_reg + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          if (bit_cnt_reg == LATCH_LAST) begin
            bit_cnt_next = 3'(BTN_A);
            state_next   = ST_SHIFT_LO;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          shreg_next[bit_cnt_reg] = sample_bit;
          state_next = (bit_cnt_reg == BIT_LAST) ? ST_DONE : ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          state_next   = ST_SHIFT_LO;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      poll_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      prev_reg      <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      pad_latch_reg <= 1'b0;
      pad_clk_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      poll_cnt_reg  <= poll_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      pad_latch_reg <= (state_next == ST_LATCH);
      pad_clk_reg   <= (state_next == ST_SHIFT_HI);
      key_valid_reg <= (state_reg == ST_DONE);
      if (state_reg == ST_DONE) begin
        prev_reg <= shreg_reg;
        // With debounce, a byte is accepted only once it repeats
        if (DEBOUNCE == 0 || shreg_reg == prev_reg) begin
          key_reg <= shreg_reg;
        end
      end
    end
  end

  assign pad_latch = pad_latch_reg;
  assign pad_clk   = pad_clk_reg;
  assign key       = key_reg;
  assign key_valid = key_valid_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_poll_ticks: assert (POLL_TICKS >= FRAME_TICKS);
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a 4021 pad model feeds two readers (debounce off/on).
module tb_nes_pad_reader;

  localparam int TICK_DIV   = 4;
  localparam int POLL_TICKS = 20;
  localparam int CLK_P      = 10;
  localparam int FIRST_LATCH = POLL_TICKS * TICK_DIV * CLK_P;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data;
  logic       pad_latch0, pad_clk0, kv0;
  logic [7:0] key0;
  logic       pad_latch1, pad_clk1, kv1;
  logic [7:0] key1;

  int n_cmp = 0;
  int n_bad = 0;

  always #(CLK_P / 2) clk = ~clk;

  nes_pad_reader #(.TICK_DIV(TICK_DIV), .POLL_TICKS(POLL_TICKS), .DEBOUNCE(0)) dut0 (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch0), .pad_clk(pad_clk0), .key(key0), .key_valid(kv0)
  );

  nes_pad_reader #(.TICK_DIV(TICK_DIV), .POLL_TICKS(POLL_TICKS), .DEBOUNCE(1)) dut1 (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch1), .pad_clk(pad_clk1), .key(key1), .key_valid(kv1)
  );

  // Pad model: mode 0 = buttons, 1 = unplugged (pulled high), 2 = data stuck low
  int         pad_mode = 0;
  logic [7:0] pad_btn = 8'h00;
  logic [2:0] pad_idx = 3'd0;

  assign pad_data = (pad_mode == 1) ? 1'b1 :
                    (pad_mode == 2) ? 1'b0 : ~pad_btn[pad_idx];

  time t_rel = 0, t_lrise = 0, t_lfall = 0, t_crise = 0;
  int  clk_pulses = 0, hi_min = 1000000, hi_max = 0, latch_rises = 0, kv_cnt = 0;

  always @(posedge pad_latch0) begin
    t_lrise = $time;
    clk_pulses = 0;
    hi_min = 1000000;
    hi_max = 0;
    latch_rises = latch_rises + 1;
    pad_idx = 3'd0;
  end

  always @(negedge pad_latch0) t_lfall = $time;

  always @(posedge pad_clk0) begin
    clk_pulses = clk_pulses + 1;
    t_crise = $time;
    if (pad_idx != 3'd7) pad_idx = pad_idx + 3'd1;
  end

  always @(negedge pad_clk0) begin
    int w;
    w = int'($time - t_crise);
    if (w < hi_min) hi_min = w;
    if (w > hi_max) hi_max = w;
  end

  always @(posedge clk) if (kv0) kv_cnt <= kv_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (kv0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] btn;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int kv_before, rises_before;

    //          mode btn    dbnc=0 dbnc=1
    vecs[0]  = '{0, 8'h09, 8'h09, 8'h00};
    vecs[1]  = '{0, 8'h80, 8'h80, 8'h00};
    vecs[2]  = '{0, 8'h01, 8'h01, 8'h00};
    vecs[3]  = '{0, 8'h01, 8'h01, 8'h01};
    vecs[4]  = '{0, 8'hFF, 8'hFF, 8'h01};
    vecs[5]  = '{0, 8'h01, 8'h01, 8'h01};
    vecs[6]  = '{0, 8'h01, 8'h01, 8'h01};
    vecs[7]  = '{0, 8'h42, 8'h42, 8'h01};
    vecs[8]  = '{0, 8'h42, 8'h42, 8'h42};
    vecs[9]  = '{1, 8'h00, 8'h00, 8'h42};
    vecs[10] = '{1, 8'h00, 8'h00, 8'h00};
    vecs[11] = '{2, 8'h00, 8'hFF, 8'h00};
    vecs[12] = '{2, 8'h00, 8'hFF, 8'hFF};

    pad_mode = vecs[0].mode;
    pad_btn  = vecs[0].btn;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_latch0", 32'(pad_latch0), 0);
    check("rst_clk0", 32'(pad_clk0), 0);
    check("rst_key0", 32'(key0), 0);
    check("rst_kv0", 32'(kv0), 0);
    check("rst_latch1", 32'(pad_latch1), 0);
    check("rst_clk1", 32'(pad_clk1), 0);
    check("rst_key1", 32'(key1), 0);
    check("rst_kv1", 32'(kv1), 0);

    @(posedge clk);
    t_rel = $time;
    #1 reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      pad_mode = vecs[i].mode;
      pad_btn  = vecs[i].btn;
      wait_frame(ok);
      check($sformatf("frame%0d_seen", i), 32'(ok), 1);
      if (!ok) continue;
      if (i == 0) check("first_latch_delay", 32'(t_lrise - t_rel), FIRST_LATCH);
      $display("frame %0d: pad=0x%02h mode=%0d key0=0x%02h key1=0x%02h", i, vecs[i].btn, vecs[i].mode, key0, key1);
      check($sformatf("frame%0d_key0", i), 32'(key0), 32'(vecs[i].exp0));
      check($sformatf("frame%0d_key1", i), 32'(key1), 32'(vecs[i].exp1));
      check($sformatf("frame%0d_kv1", i), 32'(kv1), 1);
      check($sformatf("frame%0d_pulses", i), 32'(clk_pulses), 7);
      check($sformatf("frame%0d_latch_w", i), 32'(t_lfall - t_lrise), 2 * TICK_DIV * CLK_P);
      check($sformatf("frame%0d_clk_hi_min", i), 32'(hi_min), TICK_DIV * CLK_P);
      check($sformatf("frame%0d_clk_hi_max", i), 32'(hi_max), TICK_DIV * CLK_P);
      @(negedge clk);
      check($sformatf("frame%0d_kv_single", i), 32'(kv0), 0);
    end

    // Abort a frame with reset during the SHIFT_HI phase of bit 3
    pad_mode = 0;
    pad_btn  = 8'h5A;
    kv_before = kv_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pad_clk0 && clk_pulses == 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reach_bit3_hi", 32'(ok), 1);
    reset = 1'b1;
    @(posedge clk);
    t_rel = $time;
    #1 reset = 1'b0;
    @(negedge clk);
    $display("abort: latch=%0b clk=%0b key0=0x%02h kv0=%0b", pad_latch0, pad_clk0, key0, kv0);
    check("abort_clk", 32'(pad_clk0), 0);
    check("abort_latch", 32'(pad_latch0), 0);
    check("abort_key0", 32'(key0), 0);
    check("abort_key1", 32'(key1), 0);
    check("abort_kv", 32'(kv0), 0);
    check("abort_no_valid", 32'(kv_cnt - kv_before), 0);

    rises_before = latch_rises;
    wait_frame(ok);
    check("restart_seen", 32'(ok), 1);
    if (ok) begin
      $display("restart frame: key0=0x%02h key1=0x%02h", key0, key1);
      check("restart_latch_delay", 32'(t_lrise - t_rel), FIRST_LATCH);
      check("restart_one_latch", 32'(latch_rises - rises_before), 1);
      check("restart_pulses", 32'(clk_pulses), 7);
      check("restart_key0", 32'(key0), 32'h5A);
      check("restart_key1", 32'(key1), 32'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
